// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the PC redirect unit and its target calculator.
package pc_redirect_unit_pkg;

    localparam int XLEN = 32;
    localparam int PC_STEP = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_e;

endpackage

// File: rtl/pc_redirect_unit_target_calc.sv
// Control-transfer target selection and alignment check for the EX instruction.
module pc_target_calc
    import pc_redirect_unit_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         is_jalr,
    input  logic [W-1:0] ex_pc,
    input  logic [W-1:0] ex_imm,
    input  logic [W-1:0] ex_rs1,
    output logic [W-1:0] target,
    output logic         misaligned
);

    logic [W-1:0] jalr_sum;
    logic [W-1:0] pcrel_sum;

    assign jalr_sum  = ex_rs1 + ex_imm;
    assign pcrel_sum = ex_pc + ex_imm;

    // JALR outranks JAL/branch; both of those share the pc-relative adder.
    always_comb begin
        target = pcrel_sum;
        if (is_jalr) begin
            target = {jalr_sum[W-1:1], 1'b0};
        end
        misaligned = target[1];
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, stall hold, EX redirect with flushes, misaligned-target trap.
// Optional branch statistics counters are built when PC_REDIRECT_PERF_EN is defined.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int                XLEN_P   = XLEN,
    parameter logic [XLEN_P-1:0] RESET_PC = XLEN_P'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic              branch_flag,
    input  logic [XLEN_P-1:0] ex_pc,
    input  logic [XLEN_P-1:0] ex_imm,
    input  logic [XLEN_P-1:0] ex_rs1,
    output logic [XLEN_P-1:0] pc,
    output logic              pc_valid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              trap,
    output logic [XLEN_P-1:0] trap_pc
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       taken_count
`endif
);

    state_e            state_reg;
    logic [XLEN_P-1:0] pc_reg;
    logic [XLEN_P-1:0] trap_pc_reg;
    logic              pc_valid_reg;
    logic              trap_reg;

    logic              redir;
    logic              in_run;
    logic [XLEN_P-1:0] target;
    logic              misaligned;

    pc_target_calc #(
        .W (XLEN_P)
    ) u_target (
        .is_jalr    (ex_jalr),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .target     (target),
        .misaligned (misaligned)
    );

    assign redir  = ex_valid & (ex_jalr | ex_jal | (ex_branch & branch_flag));
    assign in_run = (state_reg == RUN);

    // Flushes are combinational so the younger instructions die in the resolving cycle.
    assign flush_ifid = in_run & redir;
    assign flush_idex = in_run & redir;

    assign pc       = pc_reg;
    assign pc_valid = pc_valid_reg;
    assign trap     = trap_reg;
    assign trap_pc  = trap_pc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            trap_pc_reg  <= '0;
            pc_valid_reg <= 1'b0;
            trap_reg     <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg    <= RUN;
                    pc_valid_reg <= 1'b1;
                end
                RUN: begin
                    if (redir) begin
                        if (misaligned) begin
                            state_reg    <= TRAP;
                            trap_pc_reg  <= target;
                            pc_valid_reg <= 1'b0;
                            trap_reg     <= 1'b1;
                        end else begin
                            pc_reg <= target;
                        end
                    end else if (!stall) begin
                        pc_reg <= pc_reg + XLEN_P'(PC_STEP);
                    end
                end
                TRAP: begin
                    // Parked until reset; every input is ignored.
                end
                default: begin
                    state_reg    <= BOOT;
                    pc_valid_reg <= 1'b0;
                    trap_reg     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] br_count_reg;
    logic [31:0] taken_count_reg;

    assign br_count    = br_count_reg;
    assign taken_count = taken_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_reg    <= '0;
            taken_count_reg <= '0;
        end else if (in_run && ex_valid && ex_branch) begin
            br_count_reg <= br_count_reg + 32'd1;
            if (branch_flag) begin
                taken_count_reg <= taken_count_reg + 32'd1;
            end
        end
    end
`endif

endmodule
